qam_demodulation: RTL and testbench

QAM_DEMODULATION -- requirements
Module: qam_demodulation

---
 rtl/qam_demodulation.sv | 214 +++++++++++++++++++++
 tb/tb_qam_demodulation.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_demodulation.sv
// ---------------------------------------------------------------------------
// qam_demodulation
//
// Takes 16-QAM symbol decisions (2 in-phase bits, 2 quadrature bits),
// serialises them into a 1 bit/clk stream, and runs a synchronisation
// checker on that stream.
//
// The checker expects the 7-bit m-sequence s(n+3) = s(n) XOR s(n+1).
// It hunts for a non-zero seed and confirms a run of correct predictions.
// It then flywheels in LOCK, counting mismatches and dropping lock when too
// many land in one window.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst        : asynchronous, active-low reset
//   SigI[1:0]  : in-phase symbol bits
//   SigQ[1:0]  : quadrature symbol bits
//   sym_valid  : SigI/SigQ carry a symbol this cycle
//   sym_ready  : a symbol is accepted this cycle if sym_valid is also high
//   ser_bit    : recovered serial bit (SigI[1], SigI[0], SigQ[1], SigQ[0])
//   ser_valid  : ser_bit is valid this cycle
//   locked     : checker is in LOCK (registered)
//   bit_err    : one-cycle pulse, prediction mismatch seen while locked
//   err_total  : saturating count of bit_err pulses
// ---------------------------------------------------------------------------
module qam_demodulation #(
    parameter int LOCK_CNT = 7,
    parameter int LOSS_ERR = 3,
    parameter int WIN      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  SigI,
    input  logic [1:0]  SigQ,
    input  logic        sym_valid,
    output logic        sym_ready,
    output logic        ser_bit,
    output logic        ser_valid,
    output logic        locked,
    output logic        bit_err,
    output logic [15:0] err_total
);

    localparam int MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
    localparam int WIN_W   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int ERR_W   = (LOSS_ERR > 1) ? $clog2(LOSS_ERR + 1) : 1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    // Serialiser state
    logic               ready_en;
    logic [2:0]         shift_buf;
    logic [1:0]         shift_rem;

    // Checker state and next-state values
    state_t             state, state_n;
    logic [2:0]         hist, hist_n;
    logic [1:0]         fill_cnt, fill_n;
    logic [MATCH_W-1:0] match_cnt, match_n;
    logic [WIN_W-1:0]   win_cnt, win_n;
    logic [ERR_W-1:0]   win_err, werr_n;
    logic               bit_err_n;
    logic [15:0]        err_total_n;
    logic               predict;
    logic               win_wrap;

    // The serialiser can take a new symbol once the first three bits of the
    // current one have left, which makes back-to-back symbols gap-free.
    // ready_en holds sym_ready low until the first clock after reset.
    assign sym_ready = ready_en && (shift_rem == 2'd0);

    // Serialiser: the first bit (SigI[1]) is registered straight onto
    // ser_bit at acceptance, and the remaining three bits wait in shift_buf.
    // shift_rem counts how many of those remaining bits are still queued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en  <= 1'b0;
            shift_buf <= 3'b000;
            shift_rem <= 2'd0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (sym_valid && sym_ready) begin
                ser_bit   <= SigI[1];
                ser_valid <= 1'b1;
                shift_buf <= {SigI[0], SigQ};
                shift_rem <= 2'd3;
            end else if (shift_rem != 2'd0) begin
                ser_bit   <= shift_buf[2];
                ser_valid <= 1'b1;
                shift_buf <= {shift_buf[1:0], 1'b0};
                shift_rem <= shift_rem - 2'd1;
            end else begin
                ser_bit   <= 1'b0;
                ser_valid <= 1'b0;
            end
        end
    end

    // The prediction follows the sequence recurrence, with hist[2] oldest.
    // The window wraps on the bit whose counter value is WIN-1.
    assign predict  = hist[2] ^ hist[1];
    assign win_wrap = (win_cnt == WIN_W'(WIN - 1));

    // Checker next-state logic. Nothing moves on cycles without a serial bit.
    // In LOCK the history is fed from the prediction (flywheel), so a
    // corrupted bit never pollutes later predictions. A loss of lock wins
    // over a simultaneous window wrap. An error on the wrapping bit that
    // does not cause loss is retired along with the window it ends.
    always_comb begin
        state_n     = state;
        hist_n      = hist;
        fill_n      = fill_cnt;
        match_n     = match_cnt;
        win_n       = win_cnt;
        werr_n      = win_err;
        bit_err_n   = 1'b0;
        err_total_n = err_total;

        if (ser_valid) begin
            unique case (state)
                HUNT: begin
                    hist_n = {hist[1:0], ser_bit};
                    if (fill_cnt != 2'd3) begin
                        fill_n = fill_cnt + 2'd1;
                    end
                    if ((fill_cnt >= 2'd2) && (hist_n != 3'b000)) begin
                        state_n = CHECK;
                        match_n = '0;
                    end
                end
                CHECK: begin
                    hist_n = {hist[1:0], ser_bit};
                    if (ser_bit == predict) begin
                        if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            state_n = LOCK;
                            match_n = '0;
                            win_n   = '0;
                            werr_n  = '0;
                        end else begin
                            match_n = match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        state_n = HUNT;
                        fill_n  = 2'd0;
                        match_n = '0;
                    end
                end
                LOCK: begin
                    hist_n = {hist[1:0], predict};
                    win_n  = win_wrap ? '0 : (win_cnt + WIN_W'(1));
                    if (ser_bit != predict) begin
                        bit_err_n = 1'b1;
                        if (err_total != 16'hFFFF) begin
                            err_total_n = err_total + 16'd1;
                        end
                        if (win_err == ERR_W'(LOSS_ERR - 1)) begin
                            state_n = HUNT;
                            fill_n  = 2'd0;
                            match_n = '0;
                            win_n   = '0;
                            werr_n  = '0;
                        end else if (win_wrap) begin
                            werr_n = '0;
                        end else begin
                            werr_n = win_err + ERR_W'(1);
                        end
                    end else if (win_wrap) begin
                        werr_n = '0;
                    end
                end
                default: begin
                    state_n = HUNT;
                    fill_n  = 2'd0;
                    match_n = '0;
                    win_n   = '0;
                    werr_n  = '0;
                end
            endcase
        end
    end

    // Checker registers. locked is registered from the next state so that it
    // rises on the same edge that enters LOCK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            hist      <= 3'b000;
            fill_cnt  <= 2'd0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            bit_err   <= 1'b0;
            err_total <= 16'd0;
            locked    <= 1'b0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            fill_cnt  <= fill_n;
            match_cnt <= match_n;
            win_cnt   <= win_n;
            win_err   <= werr_n;
            bit_err   <= bit_err_n;
            err_total <= err_total_n;
            locked    <= (state_n == LOCK);
        end
    end

endmodule

// File: tb/tb_qam_demodulation.sv
// ---------------------------------------------------------------------------
// tb_qam_demodulation
//
// Self-checking bench for qam_demodulation. Expected serial bits are queued
// when a symbol is accepted and popped by a monitor as ser_valid bits appear.
// The monitor also logs, per received bit, the locked/bit_err values seen
// after the checker has consumed that bit. Those values are checked by the
// scenario tasks against values derived from the sequence and the
// lock/loss thresholds.
// ---------------------------------------------------------------------------
module tb_qam_demodulation;

    localparam int HIST = 64;

    logic        clk;
    logic        rst;
    logic [1:0]  SigI;
    logic [1:0]  SigQ;
    logic        sym_valid;
    logic        sym_ready;
    logic        ser_bit;
    logic        ser_valid;
    logic        locked;
    logic        bit_err;
    logic [15:0] err_total;

    int vectors     = 0;
    int miscompares = 0;

    logic sb[$];
    logic lock_hist[HIST];
    logic err_hist[HIST];
    int   cyc_hist[HIST];
    int   bit_idx    = 0;
    int   prev_idx   = 0;
    bit   prev_valid = 1'b0;
    int   err_pulses = 0;
    int   cycle      = 0;

    bit mseq[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    qam_demodulation dut (
        .clk       (clk),
        .rst       (rst),
        .SigI      (SigI),
        .SigQ      (SigQ),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .locked    (locked),
        .bit_err   (bit_err),
        .err_total (err_total)
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges the bench
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: scoreboard for serial bits, plus per-bit log of the checker's
    // response. Everything is flushed while reset is held.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            bit_idx    = 0;
            prev_valid = 1'b0;
            err_pulses = 0;
            cycle      = 0;
            for (int k = 0; k < HIST; k++) begin
                lock_hist[k] = 1'bx;
                err_hist[k]  = 1'bx;
                cyc_hist[k]  = -1;
            end
        end else begin
            cycle++;
            if (bit_err === 1'b1) err_pulses++;
            if (prev_valid) begin
                lock_hist[prev_idx] = locked;
                err_hist[prev_idx]  = bit_err;
            end
            prev_valid = 1'b0;
            if (ser_valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL ser_bit_unexpected: got ser_valid with bit %0b, required no output", ser_bit);
                end else begin
                    logic exp_bit;
                    exp_bit = sb.pop_front();
                    if (ser_bit !== exp_bit) begin
                        miscompares++;
                        $display("[TB] FAIL ser_bit[%0d]: got %0b, required %0b", bit_idx, ser_bit, exp_bit);
                    end
                end
                if (bit_idx < HIST) begin
                    cyc_hist[bit_idx] = cycle;
                    prev_idx   = bit_idx;
                    prev_valid = 1'b1;
                end
                bit_idx++;
            end
        end
    end

    // Offer one symbol and wait (bounded) until it is accepted, queueing its
    // four expected bits in transmit order. Returns just after the
    // accepting edge.
    task automatic send_symbol(input logic [1:0] i, input logic [1:0] q);
        int guard = 0;
        @(negedge clk);
        SigI      = i;
        SigQ      = q;
        sym_valid = 1'b1;
        while (sym_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sym_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: sym_ready=%0b after %0d cycles, required 1", sym_ready, guard);
        end else begin
            sb.push_back(i[1]);
            sb.push_back(i[0]);
            sb.push_back(q[1]);
            sb.push_back(q[0]);
        end
        @(posedge clk);
    endtask

    // Drop sym_valid and wait (bounded) until every queued bit has come out,
    // then give the checker time to log the last bit.
    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        sym_valid = 1'b0;
        while ((sb.size() != 0 || ser_valid === 1'b1) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: %0d bits still queued, required 0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Stream nbits of the m-sequence from 0,0,1 (or all zeros), inverting
    // the bits at positions fa/fb/fc (-1 for none), back to back.
    task automatic send_stream(input int nbits, input int fa, input int fb,
                               input int fc, input bit zero);
        for (int s = 0; s < nbits / 4; s++) begin
            logic [3:0] nib;
            for (int k = 0; k < 4; k++) begin
                int n;
                logic b;
                n = s * 4 + k;
                b = zero ? 1'b0 : mseq[n % 7];
                if (n == fa || n == fb || n == fc) b = ~b;
                nib[3 - k] = b;
            end
            send_symbol(nib[3:2], nib[1:0]);
        end
        wait_idle();
    endtask

    task automatic do_reset();
        sym_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reset values, and sym_ready only after the first edge out of reset
    task automatic test_reset();
        #1;
        vectors++;
        if ({sym_ready, ser_valid, ser_bit, locked, bit_err} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got rdy/sv/sb/lk/be=%05b, required 00000",
                     {sym_ready, ser_valid, ser_bit, locked, bit_err});
        end
        vectors++;
        if (err_total !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_err_total: got %0d, required 0", err_total);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (sym_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ready_before_edge: got %0b, required 0", sym_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (sym_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_after_edge: got %0b, required 1", sym_ready);
        end
    endtask

    // One symbol: first bit one cycle after acceptance, ser_valid for four cycles
    task automatic test_single_symbol();
        int nv = 0;
        send_symbol(2'b10, 2'b01);
        #1;
        vectors++;
        if ({ser_valid, ser_bit} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL first_bit_latency: got valid/bit=%02b, required 11", {ser_valid, ser_bit});
        end
        @(negedge clk);
        sym_valid = 1'b0;
        nv += int'(ser_valid);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            nv += int'(ser_valid);
        end
        vectors++;
        if (nv != 4) begin
            miscompares++;
            $display("[TB] FAIL valid_cycles: got %0d, required 4", nv);
        end
        wait_idle();
    endtask

    // All-zero stream never locks
    task automatic test_zero_stream();
        int nl = 0;
        do_reset();
        send_stream(40, -1, -1, -1, 1'b1);
        for (int k = 0; k < 40; k++) nl += (lock_hist[k] !== 1'b0) ? 1 : 0;
        vectors++;
        if (nl != 0 || locked !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_stream_lock: got %0d non-zero lock samples, locked=%0b, required 0", nl, locked);
        end
    endtask

    // Clean m-sequence: lock after the 10th bit, gap-free back-to-back stream
    task automatic test_back_to_back();
        do_reset();
        send_stream(20, -1, -1, -1, 1'b0);
        vectors++;
        if (lock_hist[8] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lock_early: after bit 9 locked=%0b, required 0", lock_hist[8]);
        end
        vectors++;
        if (lock_hist[9] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lock_at_10: after bit 10 locked=%0b, required 1", lock_hist[9]);
        end
        vectors++;
        if (cyc_hist[19] - cyc_hist[0] != 19) begin
            miscompares++;
            $display("[TB] FAIL gap_free: 20 bits spanned %0d cycles, required 19", cyc_hist[19] - cyc_hist[0]);
        end
        vectors++;
        if (err_pulses != 0 || err_total !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL clean_errors: got pulses=%0d err_total=%0d, required 0/0", err_pulses, err_total);
        end
    endtask

    // One inverted bit while locked: single pulse, lock held
    task automatic test_single_error();
        do_reset();
        send_stream(24, 14, -1, -1, 1'b0);
        vectors++;
        if (err_hist[14] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_pulse_bit14: got %0b, required 1", err_hist[14]);
        end
        vectors++;
        if (err_pulses != 1 || err_total !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL single_err_count: got pulses=%0d err_total=%0d, required 1/1", err_pulses, err_total);
        end
        vectors++;
        if (lock_hist[14] !== 1'b1 || lock_hist[23] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lock_held: got %0b/%0b, required 1/1", lock_hist[14], lock_hist[23]);
        end
    endtask

    // Three errors in one window drop lock; relock ten clean bits later
    task automatic test_loss_relock();
        do_reset();
        send_stream(40, 12, 14, 16, 1'b0);
        vectors++;
        if (lock_hist[15] !== 1'b1 || lock_hist[16] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL loss_on_3rd: got lock %0b/%0b after bits 16/17, required 1/0", lock_hist[15], lock_hist[16]);
        end
        vectors++;
        if (err_hist[16] !== 1'b1 || err_total !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL loss_errors: got bit_err=%0b err_total=%0d, required 1/3", err_hist[16], err_total);
        end
        vectors++;
        if (lock_hist[25] !== 1'b0 || lock_hist[26] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL relock: got lock %0b/%0b after bits 26/27, required 0/1", lock_hist[25], lock_hist[26]);
        end
        vectors++;
        if (lock_hist[39] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL relock_held: got %0b, required 1", lock_hist[39]);
        end
    endtask

    // Asynchronous reset during the 2nd bit of a symbol while locked
    task automatic test_reset_midsymbol();
        do_reset();
        send_stream(16, 12, -1, -1, 1'b0);
        vectors++;
        if (locked !== 1'b1 || err_total !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_state: got locked=%0b err_total=%0d, required 1/1", locked, err_total);
        end
        send_symbol(2'b01, 2'b10);
        #1;
        sym_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({sym_ready, ser_valid, ser_bit, locked, bit_err} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL async_reset_flags: got rdy/sv/sb/lk/be=%05b, required 00000",
                     {sym_ready, ser_valid, ser_bit, locked, bit_err});
        end
        vectors++;
        if (err_total !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_err_total: got %0d, required 0", err_total);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_symbol(2'b10, 2'b11);
        #1;
        vectors++;
        if ({ser_valid, ser_bit} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL restart_order: got valid/bit=%02b, required 11", {ser_valid, ser_bit});
        end
        wait_idle();
    endtask

    initial begin
        rst       = 1'b0;
        sym_valid = 1'b0;
        SigI      = 2'b00;
        SigQ      = 2'b00;
        test_reset();
        test_single_symbol();
        test_zero_stream();
        test_back_to_back();
        test_single_error();
        test_loss_relock();
        test_reset_midsymbol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
